parallel_bus_master: RTL
========================

Name: parallel_bus_master

Overview:
- FPGA-side master for the 8-bit simple parallel bus. The bus uses the read, register_select, enable and ack_valid pins, and feeds the pollable-memory slave directly.
- Accepts one command at a time (address plus full word, or address read).
- Sequences one address phase, then TRANSACTIONS_PER_WORD data phases, most significant slice first, using an enable/ack four-phase handshake.
- Returns read data or a timeout status. Tristating is done at top level via bus_oe.

Parameters:
- WIDTH, 8: bus width and address width.
- TRANSACTIONS_PER_WORD, 2: data phases per word; word width = TRANSACTIONS_PER_WORD*WIDTH.
- SETUP_CYCLES, 2: cycles that bus, read and register_select are stable before enable rises. Must be ≥1.
- HOLD_CYCLES, 4: cycles enable stays high after ack_valid is seen. Must be ≥2 so the slave's final write strobe fires.
- GAP_CYCLES, 2: idle cycles after ack_valid falls, before the next phase.
- TIMEOUT_CYCLES, 255: wait limit for an ack_valid edge.

Ports:
- clock  in  1  single clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_read  in  1  1=read word, 0=write word.
- cmd_address  in  WIDTH  target address.
- cmd_wdata  in  TRANSACTIONS_PER_WORD*WIDTH  write word.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_timeout  out  1  valid with rsp_valid; 1=aborted.
- rsp_rdata  out  TRANSACTIONS_PER_WORD*WIDTH  read word (writes: holds last value).
- error_count  out  16  saturating timeout count.
- bus_out  out  WIDTH  value driven onto bus.
- bus_oe  out  1  1=master drives bus.
- bus_in  in  WIDTH  bus sampled value.
- read  out  1  1=read, 0=write.
- register_select  out  1  0=address, 1=data.
- enable  out  1  strobe.
- ack_valid  in  1  slave acknowledge; master treats it as synchronous.

Behaviour:
- Reset values, applied immediately on reset_n low (including mid-transaction): cmd_ready=0 then 1 in IDLE, rsp_valid=0, rsp_timeout=0, rsp_rdata=0, error_count=0, bus_out=0, bus_oe=1, read=0, register_select=0, enable=0. The state machine returns to IDLE.
- States: IDLE, SETUP, STROBE, HOLD, RELEASE, GAP, DONE. phase counts 0 (address) to TRANSACTIONS_PER_WORD; a separate cycle counter and a timeout counter are kept.
- IDLE: on cmd_valid&cmd_ready, latch the command. Set phase=0, register_select=0, read=0, bus_oe=1, bus_out=cmd_address. Go to SETUP.
- SETUP: after SETUP_CYCLES cycles, set enable=1, clear the timeout counter, go to STROBE.
- STROBE: on ack_valid=1, go to HOLD. Otherwise increment the timeout counter; when it reaches TIMEOUT_CYCLES, go to ABORT.
- HOLD: after HOLD_CYCLES cycles:
  - If read and phase≥1, capture bus_in into slice (TRANSACTIONS_PER_WORD−phase) of rsp_rdata.
  - Set enable=0 and go to RELEASE.
- RELEASE: on ack_valid=0, go to GAP. Otherwise count timeout; at the limit, go to ABORT.
- GAP: after GAP_CYCLES cycles:
  - If phase==TRANSACTIONS_PER_WORD, go to DONE.
  - Otherwise increment phase, set register_select=1, and go to SETUP.
  - For writes: bus_out = cmd_wdata slice (TRANSACTIONS_PER_WORD−phase), MSB slice first.
  - For reads: bus_oe=0 at this edge, read=1 at the next edge (break-before-make). This requires SETUP_CYCLES≥1.
- DONE: rsp_valid=1 for one cycle. Set read=0 and register_select=0, then bus_oe=1 one cycle later, then IDLE. rsp_rdata is stable from the rsp_valid cycle until the next read completes.
- ABORT (not a separate state): set enable=0 and read=0, go to DONE with rsp_timeout=1. error_count increments, saturating at 0xFFFF. Partial read slices are left as captured.
- Read data for phases not yet reached is zeroed at command accept.
- cmd_valid while busy is ignored and not queued.
- Back-to-back commands: cmd_ready rises the cycle after bus_oe returns to 1.

Test Plan:
1. TRANSACTIONS_PER_WORD=2, write address 0x4C, data 0x2A12 to a slave model → bus_out shows 0x4C (register_select=0), then 0x2A, then 0x12 (register_select=1). Exactly 3 enable pulses, each high for HOLD_CYCLES after ack. rsp_valid with rsp_timeout=0.
2. Read address 0x4C from the same model → read=1 only while bus_oe=0, never overlapping. rsp_rdata=0x2A12. Exactly 3 enable pulses.
3. ack_valid tied 0, write command → enable drops after TIMEOUT_CYCLES. rsp_timeout=1, error_count=1. Next command is accepted normally.
4. ack_valid stuck 1 after the first phase → timeout in RELEASE, rsp_timeout=1, error_count increments. With 0xFFFF timeouts forced, error_count holds 0xFFFF.
5. reset_n pulsed low mid data phase → enable, read and register_select go to 0 immediately, bus_oe goes to 1. After reset, a fresh write of 0x1507 to 0x34 completes correctly.
6. TRANSACTIONS_PER_WORD=4: write 0x31232A12 then read it back → bus order 0x31, 0x23, 0x2A, 0x12. rsp_rdata=0x31232A12. cmd_valid held high during a transaction is not accepted twice.

Source files
------------

// File: rtl/parallel_bus_master.sv
// parallel_bus_master
//   FPGA-side master for the 8-bit simple parallel bus. Takes one command at a
//   time (write a full word or read a full word at an address), runs one
//   address phase followed by TRANSACTIONS_PER_WORD data phases (MSB slice
//   first) with a four-phase enable/ack_valid handshake, and returns the read
//   word or a timeout status.
//
// Ports
//   clock, reset_n          : clock (rising edge), async active-low reset
//   cmd_valid / cmd_ready   : command handshake; a command is taken on a cycle
//                             where both are high. cmd_ready is high only in
//                             IDLE; cmd_valid while busy is ignored.
//   cmd_read, cmd_address,  : command contents (1=read word, 0=write word)
//   cmd_wdata
//   rsp_valid, rsp_timeout, : one-cycle completion pulse, abort flag, read word
//   rsp_rdata
//   error_count             : saturating count of aborted commands
//   bus_out, bus_oe, bus_in : bus value driven / drive enable / sampled value
//   read, register_select,  : bus control pins (register_select 0=address,
//   enable, ack_valid         1=data); ack_valid is treated as synchronous
//   state_debug             : current FSM state encoding

module parallel_bus_master #(
  parameter int WIDTH                 = 8,
  parameter int TRANSACTIONS_PER_WORD = 2,
  parameter int SETUP_CYCLES          = 2,
  parameter int HOLD_CYCLES           = 4,
  parameter int GAP_CYCLES            = 2,
  parameter int TIMEOUT_CYCLES        = 255
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic                                  cmd_read,
  input  logic [WIDTH-1:0]                      cmd_address,
  input  logic [TRANSACTIONS_PER_WORD*WIDTH-1:0] cmd_wdata,
  output logic                                  rsp_valid,
  output logic                                  rsp_timeout,
  output logic [TRANSACTIONS_PER_WORD*WIDTH-1:0] rsp_rdata,
  output logic [15:0]                           error_count,
  output logic [WIDTH-1:0]                      bus_out,
  output logic                                  bus_oe,
  input  logic [WIDTH-1:0]                      bus_in,
  output logic                                  read,
  output logic                                  register_select,
  output logic                                  enable,
  input  logic                                  ack_valid,
  output logic [2:0]                            state_debug
);

  localparam int WW    = TRANSACTIONS_PER_WORD * WIDTH;
  localparam int PH_W  = $clog2(TRANSACTIONS_PER_WORD + 1);
  localparam int IDX_W = $clog2(WW);
  localparam int CYC_W = 8;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, HOLD, RELEASE, GAP, DONE
  } state_t;

  state_t            state, state_d;
  logic [PH_W-1:0]   phase, phase_d;
  logic [CYC_W-1:0]  cyc, cyc_d;
  logic [TO_W-1:0]   to_cnt, to_cnt_d;
  logic              rd_q, rd_d;
  logic [WW-1:0]     wdata_q, wdata_d;
  // Read word under assembly; copied to rsp_rdata only at completion so the
  // previous read result stays stable while a new read is in flight.
  logic [WW-1:0]     work, work_d;
  logic              cmd_ready_d, rsp_valid_d, rsp_timeout_d;
  logic [WW-1:0]     rsp_rdata_d;
  logic [15:0]       error_count_d;
  logic [WIDTH-1:0]  bus_out_d;
  logic              bus_oe_d, read_d, register_select_d, enable_d;
  logic [IDX_W-1:0]  lo_cur, lo_next;
  logic              abort, enter_done;

  assign state_debug = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      phase           <= '0;
      cyc             <= '0;
      to_cnt          <= '0;
      rd_q            <= 1'b0;
      wdata_q         <= '0;
      work            <= '0;
      cmd_ready       <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_timeout     <= 1'b0;
      rsp_rdata       <= '0;
      error_count     <= '0;
      bus_out         <= '0;
      bus_oe          <= 1'b1;
      read            <= 1'b0;
      register_select <= 1'b0;
      enable          <= 1'b0;
    end else begin
      state           <= state_d;
      phase           <= phase_d;
      cyc             <= cyc_d;
      to_cnt          <= to_cnt_d;
      rd_q            <= rd_d;
      wdata_q         <= wdata_d;
      work            <= work_d;
      cmd_ready       <= cmd_ready_d;
      rsp_valid       <= rsp_valid_d;
      rsp_timeout     <= rsp_timeout_d;
      rsp_rdata       <= rsp_rdata_d;
      error_count     <= error_count_d;
      bus_out         <= bus_out_d;
      bus_oe          <= bus_oe_d;
      read            <= read_d;
      register_select <= register_select_d;
      enable          <= enable_d;
    end
  end

  always_comb begin
    state_d           = state;
    phase_d           = phase;
    cyc_d             = cyc;
    to_cnt_d          = to_cnt;
    rd_d              = rd_q;
    wdata_d           = wdata_q;
    work_d            = work;
    cmd_ready_d       = 1'b0;
    rsp_valid_d       = 1'b0;
    rsp_timeout_d     = rsp_timeout;
    rsp_rdata_d       = rsp_rdata;
    error_count_d     = error_count;
    bus_out_d         = bus_out;
    bus_oe_d          = bus_oe;
    read_d            = read;
    register_select_d = register_select;
    enable_d          = enable;
    abort             = 1'b0;
    enter_done        = 1'b0;
    // Slice numbering: data phase 1 carries the most significant slice.
    lo_cur  = IDX_W'((TRANSACTIONS_PER_WORD - int'(phase)) * WIDTH);
    lo_next = IDX_W'((TRANSACTIONS_PER_WORD - 1 - int'(phase)) * WIDTH);

    case (state)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready) begin
          cmd_ready_d       = 1'b0;
          rd_d              = cmd_read;
          wdata_d           = cmd_wdata;
          phase_d           = '0;
          cyc_d             = '0;
          register_select_d = 1'b0;
          read_d            = 1'b0;
          bus_oe_d          = 1'b1;
          bus_out_d         = cmd_address;
          if (cmd_read) work_d = '0;
          state_d           = SETUP;
        end
      end
      SETUP: begin
        // Data phase of a read: bus_oe already dropped on the previous edge,
        // so raising read now never overlaps with the master driving.
        if (rd_q && phase != '0) read_d = 1'b1;
        if (cyc == CYC_W'(SETUP_CYCLES - 1)) begin
          enable_d = 1'b1;
          to_cnt_d = '0;
          state_d  = STROBE;
        end else begin
          cyc_d = cyc + 1'b1;
        end
      end
      STROBE: begin
        if (ack_valid) begin
          cyc_d   = '0;
          state_d = HOLD;
        end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          abort = 1'b1;
        end else begin
          to_cnt_d = to_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (cyc == CYC_W'(HOLD_CYCLES - 1)) begin
          if (rd_q && phase != '0) work_d[lo_cur +: WIDTH] = bus_in;
          enable_d = 1'b0;
          to_cnt_d = '0;
          state_d  = RELEASE;
        end else begin
          cyc_d = cyc + 1'b1;
        end
      end
      RELEASE: begin
        if (!ack_valid) begin
          cyc_d   = '0;
          state_d = GAP;
        end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          abort = 1'b1;
        end else begin
          to_cnt_d = to_cnt + 1'b1;
        end
      end
      GAP: begin
        if (cyc == CYC_W'(GAP_CYCLES - 1)) begin
          if (phase == PH_W'(TRANSACTIONS_PER_WORD)) begin
            enter_done = 1'b1;
          end else begin
            phase_d           = phase + 1'b1;
            register_select_d = 1'b1;
            cyc_d             = '0;
            state_d           = SETUP;
            if (rd_q) bus_oe_d = 1'b0;
            else      bus_out_d = wdata_q[lo_next +: WIDTH];
          end
        end else begin
          cyc_d = cyc + 1'b1;
        end
      end
      DONE: begin
        // First DONE cycle carries rsp_valid; bus_oe returns one cycle after
        // read dropped, and cmd_ready rises one cycle after that.
        if (cyc == '0) begin
          bus_oe_d = 1'b1;
          cyc_d    = 1;
        end else begin
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      enable_d   = 1'b0;
      enter_done = 1'b1;
      if (error_count != 16'hFFFF) error_count_d = error_count + 16'd1;
    end

    if (enter_done) begin
      rsp_valid_d       = 1'b1;
      rsp_timeout_d     = abort;
      read_d            = 1'b0;
      register_select_d = 1'b0;
      cyc_d             = '0;
      state_d           = DONE;
      if (rd_q) rsp_rdata_d = work_d;
    end
  end

endmodule
